// File: rtl/tick_counter.sv
// Multi-digit BCD up/down stopwatch counter stepped by rising edges of the divided-clock level.
// The divided clock is sampled on the fast system clock; the count is kept as independent BCD digits.
module tick_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  wrap
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q;
  logic           running_q;
  logic           tick_q;
  logic [W-1:0]   bcd_q, bcd_d;
  logic           wrap_q, wrap_d;
  logic           tick_ev;

  // Returns {carry_out, result}; carry_out set means the whole count rolled over.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  assign tick_ev = tick_in & ~tick_q;

  // Clear beats load beats tick; a tick is only counted in the current RUN state.
  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (clear) begin
      bcd_d = '0;
    end else if (load) begin
      bcd_d = bcd_sat(load_val);
    end else if (tick_ev && (state_q == RUN)) begin
      if (up_dn) {wrap_d, bcd_d} = bcd_inc(bcd_q);
      else       {wrap_d, bcd_d} = bcd_dec(bcd_q);
    end
  end

  // tick_q resets high so a level already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b1;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  // Run/idle FSM; stop dominates start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bcd     = bcd_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter: reset, up/down counting, wrap, priority and reset mid-run.
module tb_tick_counter;

  logic        clk;
  logic        rst;
  logic        tick_in;
  logic        start;
  logic        stop;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic        up_dn;
  logic [15:0] bcd;
  logic        running;
  logic        wrap;

  int n_cmp = 0;
  int n_bad = 0;

  tick_counter #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .up_dn    (up_dn),
    .bcd      (bcd),
    .running  (running),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic wrap_seen;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (bcd !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: bcd=%h running=%b wrap=%b, want 0000/0/0", bcd, running, wrap);
    end
    wrap_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_in = 1'b1;
      cyc();
      wrap_seen |= wrap;
      tick_in = 1'b0;
      cyc();
      wrap_seen |= wrap;
    end
    n_cmp++;
    if (bcd !== 16'h0000 || running !== 1'b0 || wrap_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ticks: bcd=%h running=%b wrap_seen=%b, want 0000/0/0", bcd, running, wrap_seen);
    end
  endtask

  task automatic test_up_count();
    int bad_steps;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    up_dn = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++;
    if (running !== 1'b1) begin
      n_bad++;
      $display("FAIL start_running: running=%b, want 1", running);
    end
    bad_steps = 0;
    for (int i = 1; i <= 12; i++) begin
      tick_in = 1'b1;
      cyc();
      if (bcd !== to_bcd(i)) begin
        bad_steps++;
        $display("step %0d: bcd=%h want %h", i, bcd, to_bcd(i));
      end
      tick_in = 1'b0;
      cyc();
    end
    n_cmp++;
    if (bad_steps != 0) begin
      n_bad++;
      $display("FAIL up_latency: %0d late or wrong steps, want 0", bad_steps);
    end
    n_cmp++;
    if (bcd !== 16'h0012) begin
      n_bad++;
      $display("FAIL up_12: bcd=%h, want 0012", bcd);
    end
    tick_in = 1'b1;
    repeat (10) cyc();
    tick_in = 1'b0;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0013) begin
      n_bad++;
      $display("FAIL hold_high: bcd=%h, want 0013", bcd);
    end
  endtask

  task automatic test_up_wrap();
    do_load(16'h9998);
    n_cmp++;
    if (bcd !== 16'h9998) begin
      n_bad++;
      $display("FAIL load_9998: bcd=%h, want 9998", bcd);
    end
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h9999 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL up_9999: bcd=%h wrap=%b, want 9999/0", bcd, wrap);
    end
    tick_in = 1'b0;
    cyc();
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0000 || wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL up_wrap: bcd=%h wrap=%b, want 0000/1", bcd, wrap);
    end
    tick_in = 1'b0;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0000 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_one_cycle: bcd=%h wrap=%b, want 0000/0", bcd, wrap);
    end
  endtask

  task automatic test_down();
    up_dn = 1'b0;
    do_load(16'h0100);
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0099 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL down_borrow: bcd=%h wrap=%b, want 0099/0", bcd, wrap);
    end
    tick_in = 1'b0;
    cyc();
    do_load(16'h0000);
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h9999 || wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL down_wrap: bcd=%h wrap=%b, want 9999/1", bcd, wrap);
    end
    tick_in = 1'b0;
    cyc();
  endtask

  task automatic test_priority();
    up_dn = 1'b1;
    do_load(16'h0005);
    clear = 1'b1;
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0000 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_vs_tick: bcd=%h wrap=%b, want 0000/0", bcd, wrap);
    end
    clear = 1'b0;
    tick_in = 1'b0;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0000) begin
      n_bad++;
      $display("FAIL tick_discarded: bcd=%h, want 0000", bcd);
    end
    do_load(16'h0FA3);
    n_cmp++;
    if (bcd !== 16'h0993) begin
      n_bad++;
      $display("FAIL load_sat: bcd=%h, want 0993", bcd);
    end
    stop = 1'b1;
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0994 || running !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_with_tick: bcd=%h running=%b, want 0994/0", bcd, running);
    end
    stop = 1'b0;
    tick_in = 1'b0;
    cyc();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0994) begin
      n_bad++;
      $display("FAIL idle_no_count: bcd=%h, want 0994", bcd);
    end
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    n_cmp++;
    if (running !== 1'b0) begin
      n_bad++;
      $display("FAIL start_stop_both: running=%b, want 0", running);
    end
    start = 1'b1;
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (running !== 1'b1 || bcd !== 16'h0994) begin
      n_bad++;
      $display("FAIL start_latency: running=%b bcd=%h, want 1/0994", running, bcd);
    end
    start = 1'b0;
    tick_in = 1'b0;
    cyc();
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0995) begin
      n_bad++;
      $display("FAIL first_run_tick: bcd=%h, want 0995", bcd);
    end
    tick_in = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_run();
    up_dn = 1'b1;
    do_load(16'h0036);
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0037) begin
      n_bad++;
      $display("FAIL count_37: bcd=%h, want 0037", bcd);
    end
    tick_in = 1'b0;
    cyc();
    rst = 1'b1;
    tick_in = 1'b1;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_run: bcd=%h running=%b wrap=%b, want 0000/0/0", bcd, running, wrap);
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (bcd !== 16'h0000) begin
      n_bad++;
      $display("FAIL no_edge_after_rst: bcd=%h, want 0000", bcd);
    end
    tick_in = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    tick_in = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    clear = 1'b0;
    load = 1'b0;
    load_val = 16'h0000;
    up_dn = 1'b1;
    test_reset();
    test_up_count();
    test_up_wrap();
    test_down();
    test_priority();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_counter.md
# tick_counter

Multi-digit BCD up/down counter that consumes the divided clock `clk_div` produced by the clock-divider stage and advances once per rising edge of it. All logic runs on the fast system clock, and `clk_div` is treated as a level input, not as a clock. The BCD output drives the display/decoder stage. A two-state run/idle FSM, plus clear and load controls, provide stopwatch-style operation.

## Interface
- `DIGITS`, default 4: number of BCD digits; count range 0 to 10^DIGITS−1.
- `clk`, input, 1: system clock, the same clock that feeds the divider.
- `rst`, input, 1: reset, synchronous, active-high.
- `tick_in`, input, 1: divided-clock level from the divider; synchronous to `clk`.
- `start`, input, 1: level-sampled; IDLE→RUN.
- `stop`, input, 1: level-sampled; RUN→IDLE.
- `clear`, input, 1: force count to 0.
- `load`, input, 1: load `load_val` into the count.
- `load_val`, input, 4*DIGITS: BCD value; digit 0 is in bits [3:0].
- `up_dn`, input, 1: 1 = count up, 0 = count down.
- `bcd`, output, 4*DIGITS: current count, registered.
- `running`, output, 1: 1 while the FSM is in RUN.
- `wrap`, output, 1: one-cycle pulse on count wrap-around.

## Operation
- **Tick event**
  - `tick_q` registers `tick_in` every cycle.
  - `tick_ev = tick_in & ~tick_q`, i.e. a rising edge of `tick_in`.
  - Falling edges are ignored.
- **FSM states:** IDLE and RUN.
  - IDLE→RUN when `start=1` and `stop=0`.
  - RUN→IDLE when `stop=1`.
  - `start` and `stop` both high: stop wins, and the next state is IDLE.
- **Per-cycle count update priority, highest first:**
  1. `clear` sets the count to 0, in any state.
  2. `load` sets the count to `load_val`, in any state. Any digit >9 is loaded as 9.
  3. `tick_ev` while in RUN (current state, not next) steps the count by ±1 according to `up_dn`.
  4. Otherwise the count holds.
- A tick that coincides with `clear` or `load` is discarded, not deferred.
- `clear` and `load` do not change the FSM state.
- **Up count:** digit 0 increments; a digit at 9 becomes 0 and carries to the next digit.
  - 99…9 → 00…0 asserts `wrap`.
- **Down count:** a digit at 0 becomes 9 and borrows from the next digit.
  - 00…0 → 99…9 asserts `wrap`.
- `wrap` asserts only on a tick-driven step, never on clear or load.

## Timing
- **Reset values:** `bcd`=0, `running`=0, `wrap`=0, state IDLE.
  - `tick_q` resets to 1, so `tick_in` already high at reset release produces no event.
- **Tick latency:** `tick_in` is first sampled high at clock edge N (with `tick_q`=0). `bcd` shows the new value after edge N, so it is visible during cycle N+1. `wrap` is high in that same cycle only.
- **Start latency:** `start` sampled at edge N gives `running`=1 after edge N. A tick event sampled at edge N is not counted; the first countable event is at edge N+1.
- **Stop:** `stop` sampled at edge N gives `running`=0 after edge N. A tick event at edge N is still counted, because the FSM was in RUN.
- **Clear/load latency:** one cycle; the value is visible after the sampling edge.
- **Reset mid-operation:** `rst` overrides everything in the same edge, including a coincident tick, load or clear.
- **Back-to-back events:** each requires `tick_in` to go low for at least one cycle. The divider output guarantees this.
- **Width:** the count is held as DIGITS independent 4-bit fields. No binary intermediate is used.

## Test plan
- **Reset/idle:** after `rst`, toggle `tick_in` 5 times with no `start` → `bcd`=0000, `running`=0, `wrap` never asserted.
- **Up count with latency:** `start`, `up_dn`=1, 12 rising edges of `tick_in` → `bcd`=0012. Each step appears exactly one cycle after `tick_in` rises. Holding `tick_in` high for many cycles adds only 1.
- **Up wrap:** `load` 9998, RUN, `up_dn`=1, 2 ticks → 9999 then 0000. `wrap` is high for exactly the cycle `bcd` first shows 0000.
- **Down borrow and wrap:** `load` 0100, `up_dn`=0, 1 tick → 0099. `load` 0000, 1 tick → 9999 with `wrap`=1.
- **Priority and collisions:**
  - `clear` coincident with a tick in RUN → 0000, with no step.
  - `load_val`=0xFA3 → loads 0993.
  - `start`+`stop` together from IDLE → stays IDLE.
  - `stop` coincident with a tick → that tick is counted, `running`=0.
- **Reset mid-run:** count to 0037, then assert `rst` together with a tick event → `bcd`=0000, `running`=0, `wrap`=0 on the next cycle.
